serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Sequencing controller for a bit-serial add: accepts two WIDTH-bit operands under a start/done handshake and steps a one-bit registered full-adder stage across them LSB-first, one bit per clock. It trades WIDTH cycles of latency for a single adder cell. The ALU uses it as a low-area adder path, and it serves as the integration harness for the one-bit adder cell.

## Interface
Parameters:
- WIDTH, 32: operand and result width; legal range 2–64.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; latched when start is accepted.
- b  in  WIDTH  operand B; latched when start is accepted.
- cin  in  1  carry-in; latched when start is accepted.
- sub  in  1  subtract select; present only with SERIAL_ADD_SUB_EN.
- busy  out  1  high while bits are being processed (SHIFT state).
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; holds the last result until the next completion.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States:
  - IDLE: start=1 latches a, b and cin into shift registers, clears the bit counter, and moves to SHIFT. start=0 stays in IDLE.
  - SHIFT: each cycle computes bit cnt with s = a0^b0^c and c' = maj(a0,b0,c).
    - s is shifted into the result register MSB-side.
    - The operand registers shift right.
    - The carry flop loads c'.
    - The counter increments.
    - When cnt == WIDTH-1, the block captures the carry into the MSB (the pre-update carry) and moves to DONE.
  - DONE: done=1 for one cycle, then IDLE unconditionally.
- Output updates on the edge entering DONE:
  - sum takes the assembled result.
  - cout takes the final carry.
  - ovf takes carry-into-MSB XOR final carry.
  - These outputs hold until the next edge entering DONE.
- busy = (state == SHIFT). done = (state == DONE).
- start is ignored in SHIFT and DONE: no queueing, no restart, operands unaffected.
- Changing a, b or cin after acceptance has no effect on the operation in progress.
- Arithmetic is modulo 2^WIDTH. The counter is ceil(log2(WIDTH)) bits wide and never wraps within an operation.
- Reset, including mid-operation:
  - State goes to IDLE; the operation in progress is abandoned with no done pulse.
  - sum, cout, ovf, busy, done, the carry flop, the counter and the shift registers all clear to 0.

## Timing
- start is accepted at edge k; busy is high from after edge k through edge k+WIDTH.
- done is high for exactly the cycle after edge k+WIDTH. Latency is WIDTH+1 edges from acceptance to the done-high cycle.
- The earliest next acceptance is edge k+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- If rst and start are high on the same edge, reset wins.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists.
  - With sub=1 at acceptance, the block latches ~b and sets the carry to 1, ignoring cin. The result is a−b.
  - cout=1 means no borrow. ovf is signed overflow of the subtraction.
- SERIAL_ADD_SUB_EN undefined:
  - The sub port is absent and the block is add-only.
  - Behaviour is otherwise identical.

## Test plan
All cases use WIDTH=8.
- 0x0F+0x01, cin=0, start at edge k → busy for 8 cycles, done in the cycle after edge k+8, sum=0x10, cout=0, ovf=0.
- 0xFF+0x01, cin=0 → sum=0x00, cout=1, ovf=0. 0x7F+0x00, cin=1 → sum=0x80, cout=0, ovf=1.
- start pulsed at cycle 3 of SHIFT with different operands → ignored; original result delivered; exactly one done pulse.
- rst asserted at cycle 4 of SHIFT → next cycle busy=0, done=0, sum=0; no done follows. A fresh 0x12+0x34 then yields 0x46.
- With SERIAL_ADD_SUB_EN: 0x05−0x07, sub=1 → sum=0xFE, cout=0. 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
- Back-to-back: start held high continuously → accepts every 10 cycles; done pulses are spaced 10 cycles apart.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: steps a one-bit registered full-adder LSB-first across WIDTH-bit operands.
// Optional subtract mode (sub port, a-b via ~b and carry-in 1) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_c;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic               w_s;
    logic               w_c_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_c_in;

    // Operand B and carry-in as loaded at acceptance
`ifdef SERIAL_ADD_SUB_EN
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : cin;
`else
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    // One-bit full-adder cell on the current LSBs
    assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c_next = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_c     <= w_c_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_res <= {w_s, r_res[WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_c_next;
                    // r_c here is still the carry into the MSB on the last step
                    if (w_last) begin
                        r_sum   <= {w_s, r_res[WIDTH-1:1]};
                        r_cout  <= w_c_next;
                        r_ovf   <= r_c ^ w_c_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8; subtract cases build only with SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and wait (bounded) for done; lat = edges after acceptance
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                          input logic ts, output int lat, output int bcnt);
        a = ta; b = tbv; cin = tc; sub = ts; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0;
        step(); step();
        rst = 1'b0; start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", sum); end
        total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {cout, ovf}); end
    endtask

    task automatic test_add();
        logic [W-1:0] va [3] = '{8'h0F, 8'hFF, 8'h7F};
        logic [W-1:0] vb [3] = '{8'h01, 8'h01, 8'h00};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [3] = '{8'h10, 8'h00, 8'h80};
        logic         eco[3] = '{1'b0, 1'b1, 1'b0};
        logic         eov[3] = '{1'b0, 1'b0, 1'b1};
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b0, lat, bcnt);
            total++; if (lat != 8) begin bad++; $display("FAIL add%0d_latency got=%0d exp=8", i, lat); end
            total++; if (bcnt != 8) begin bad++; $display("FAIL add%0d_busy_cycles got=%0d exp=8", i, bcnt); end
            total++; if (sum !== es[i]) begin bad++; $display("FAIL add%0d_sum got=%h exp=%h", i, sum, es[i]); end
            total++; if (cout !== eco[i]) begin bad++; $display("FAIL add%0d_cout got=%b exp=%b", i, cout, eco[i]); end
            total++; if (ovf !== eov[i]) begin bad++; $display("FAIL add%0d_ovf got=%b exp=%b", i, ovf, eov[i]); end
            step();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL add%0d_done_width got=%b exp=0", i, done); end
            total++; if (sum !== es[i]) begin bad++; $display("FAIL add%0d_sum_hold got=%h exp=%h", i, sum, es[i]); end
        end
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; end
            else start = 1'b0;
            if (done) ndone++;
            step();
        end
        start = 1'b0;
        total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        total++; if (sum !== 8'h10) begin bad++; $display("FAIL ignore_sum got=%h exp=10", sum); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        int lat, bcnt;
        a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL midrst_sum got=%h exp=00", sum); end
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            step();
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
        run_op(8'h12, 8'h34, 1'b0, 1'b0, lat, bcnt);
        total++; if (lat != 8) begin bad++; $display("FAIL midrst_fresh_latency got=%0d exp=8", lat); end
        total++; if (sum !== 8'h46) begin bad++; $display("FAIL midrst_fresh_sum got=%h exp=46", sum); end
        total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL midrst_fresh_flags got=%b exp=00", {cout, ovf}); end
        step();
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int lat, bcnt;
        run_op(8'h05, 8'h07, 1'b0, 1'b1, lat, bcnt);
        total++; if (sum !== 8'hFE) begin bad++; $display("FAIL sub0_sum got=%h exp=fe", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL sub0_cout got=%b exp=0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL sub0_ovf got=%b exp=0", ovf); end
        step();
        run_op(8'h80, 8'h01, 1'b0, 1'b1, lat, bcnt);
        total++; if (sum !== 8'h7F) begin bad++; $display("FAIL sub1_sum got=%h exp=7f", sum); end
        total++; if (cout !== 1'b1) begin bad++; $display("FAIL sub1_cout got=%b exp=1", cout); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sub1_ovf got=%b exp=1", ovf); end
        step();
        sub = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        int t_done[$];
        a = 8'h21; b = 8'h43; cin = 1'b1; start = 1'b1;
        for (int i = 0; i < 36; i++) begin
            step();
            if (done) begin
                t_done.push_back(i);
                total++; if (sum !== 8'h65) begin bad++; $display("FAIL b2b_sum got=%h exp=65", sum); end
            end
        end
        start = 1'b0;
        total++; if (t_done.size() != 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", t_done.size()); end
        for (int i = 1; i < t_done.size(); i++) begin
            total++;
            if (t_done[i] - t_done[i-1] != 10) begin
                bad++; $display("FAIL b2b_spacing%0d got=%0d exp=10", i, t_done[i] - t_done[i-1]);
            end
        end
        step(); step(); step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_add();
        test_start_ignored();
        test_reset_mid();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
